sysbus_arbiter: RTL and testbench

- Shares the single Sysbus master port between N requesters: instruction fetch, page-table walker, data port.
- Handles read-line transactions only: one 64-byte line, BEATS data beats per transaction.
- One transaction outstanding at a time; the arbiter owns the bus handshake and routes response beats to the owning requester.
- Sits between the core pipeline / VA-to-PA walker and the Sysbus pins of top.

---
 rtl/sysbus_pkg.sv | 22 ++
 rtl/sysbus_arbiter_rr_grant.sv | 53 +++++
 rtl/sysbus_arbiter.sv | 119 +++++++++++
 tb/tb_sysbus_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sysbus_pkg.sv
// rtl/sysbus_pkg.sv - shared Sysbus arbiter types and constants (see SYSBUS_ARB_FIXED_PRIO_EN in sysbus_arbiter)
package sysbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LINE_BYTES       = 64;
  localparam int LINE_OFFSET_BITS = $clog2(LINE_BYTES);

  localparam int REQ_FETCH = 0;
  localparam int REQ_PTW   = 1;
  localparam int REQ_DATA  = 2;

  // Sysbus.defs encodings: read command in bit 12, memory space in bits 11:8
  localparam logic       SYSBUS_READ     = 1'b1;
  localparam logic [3:0] SYSBUS_MEMORY   = 4'b0001;
  localparam logic [12:0] SYSBUS_READ_TAG = {SYSBUS_READ, SYSBUS_MEMORY, 8'h00};

endpackage

// File: rtl/sysbus_arbiter_rr_grant.sv
// rtl/sysbus_arbiter_rr_grant.sv - combinational requester picker; fixed priority ptw>data>fetch under SYSBUS_ARB_FIXED_PRIO_EN
module sysbus_arbiter_rr_grant
  import sysbus_pkg::*;
#(
  parameter int N_REQ = 3,
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [PW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [PW-1:0]    o_idx
);

`ifdef SYSBUS_ARB_FIXED_PRIO_EN
  // Walker first so translation can always make progress
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    if (i_valid[REQ_PTW]) begin
      o_idx            = PW'(REQ_PTW);
      o_grant[REQ_PTW] = 1'b1;
    end else if (i_valid[REQ_DATA]) begin
      o_idx             = PW'(REQ_DATA);
      o_grant[REQ_DATA] = 1'b1;
    end else if (i_valid[REQ_FETCH]) begin
      o_idx              = PW'(REQ_FETCH);
      o_grant[REQ_FETCH] = 1'b1;
    end
  end
`else
  always_comb begin
    logic w_found;
    int   cand;
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    cand    = 0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = int'(i_ptr) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!w_found && i_valid[PW'(cand)]) begin
        w_found              = 1'b1;
        o_idx                = PW'(cand);
        o_grant[PW'(cand)]   = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/sysbus_arbiter.sv
// rtl/sysbus_arbiter.sv - read-line Sysbus arbiter; define SYSBUS_ARB_FIXED_PRIO_EN for fixed priority grant
module sysbus_arbiter
  import sysbus_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int N_REQ          = 3,
  parameter int BEATS          = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*BUS_DATA_WIDTH-1:0] req_addr,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            resp_valid,
  output logic [BUS_DATA_WIDTH-1:0]   resp_data,
  output logic                        resp_last,
  input  logic [N_REQ-1:0]            resp_ready,
  output logic                        bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]   bus_req,
  output logic [BUS_TAG_WIDTH-1:0]    bus_reqtag,
  input  logic                        bus_reqack,
  input  logic                        bus_respcyc,
  output logic                        bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0]   bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]    bus_resptag
);

  localparam int PW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t                      r_state;
  logic [PW-1:0]               r_owner;
  logic [BEAT_W-1:0]           r_beat;
  logic                        r_bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0]   r_bus_req;
  logic [N_REQ-1:0]            w_gnt_oh;
  logic [PW-1:0]               w_gnt_idx;
  logic [PW-1:0]               w_rr_ptr;
  logic [N_REQ-1:0]            w_owner_oh;
  logic                        w_beat_xfer;
  logic                        w_last_beat;
  logic                        w_unused;

`ifdef SYSBUS_ARB_FIXED_PRIO_EN
  assign w_rr_ptr = '0;
`else
  logic [PW-1:0] r_rr;
  assign w_rr_ptr = r_rr;
`endif

  sysbus_arbiter_rr_grant #(.N_REQ(N_REQ)) u_grant (
    .i_valid (req_valid),
    .i_ptr   (w_rr_ptr),
    .o_grant (w_gnt_oh),
    .o_idx   (w_gnt_idx)
  );

  assign w_owner_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;
  assign w_last_beat = (r_beat == BEAT_W'(BEATS-1));
  assign bus_respack = (r_state == RESP) && bus_respcyc && resp_ready[r_owner];
  assign w_beat_xfer = bus_respcyc && bus_respack;

  assign req_ready   = (r_state == REQ && bus_reqack) ? w_owner_oh : '0;
  assign resp_valid  = (r_state == RESP && bus_respcyc) ? w_owner_oh : '0;
  assign resp_data   = bus_resp;
  assign resp_last   = (r_state == RESP) && w_last_beat;
  assign bus_reqcyc  = r_bus_reqcyc;
  assign bus_req     = r_bus_req;
  assign bus_reqtag  = BUS_TAG_WIDTH'(SYSBUS_READ_TAG);

  assign w_unused = ^{bus_resptag, w_gnt_oh};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= PW'(REQ_FETCH);
      r_beat       <= '0;
      r_bus_reqcyc <= 1'b0;
      r_bus_req    <= '0;
`ifndef SYSBUS_ARB_FIXED_PRIO_EN
      r_rr         <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_owner      <= w_gnt_idx;
            r_bus_req    <= {req_addr[w_gnt_idx*BUS_DATA_WIDTH + LINE_OFFSET_BITS +: (BUS_DATA_WIDTH-LINE_OFFSET_BITS)],
                             {LINE_OFFSET_BITS{1'b0}}};
            r_bus_reqcyc <= 1'b1;
            r_state      <= REQ;
          end
        end
        REQ: begin
          if (bus_reqack) begin
            r_bus_reqcyc <= 1'b0;
            r_beat       <= '0;
            r_state      <= RESP;
          end
        end
        RESP: begin
          if (w_beat_xfer) begin
            r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
            if (w_last_beat) begin
              r_state <= IDLE;
`ifndef SYSBUS_ARB_FIXED_PRIO_EN
              // Rotate past the finished owner so the others get the next turn
              r_rr    <= (r_owner == PW'(N_REQ-1)) ? '0 : r_owner + 1'b1;
`endif
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// tb/tb_sysbus_arbiter.sv - directed table-driven bench for sysbus_arbiter
module tb_sysbus_arbiter;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    req_valid;
  logic [191:0]  req_addr;
  logic [2:0]    req_ready;
  logic [2:0]    resp_valid;
  logic [63:0]   resp_data;
  logic          resp_last;
  logic [2:0]    resp_ready;
  logic          bus_reqcyc;
  logic [63:0]   bus_req;
  logic [12:0]   bus_reqtag;
  logic          bus_reqack;
  logic          bus_respcyc;
  logic          bus_respack;
  logic [63:0]   bus_resp;
  logic [12:0]   bus_resptag;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sysbus_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_last   (resp_last),
    .resp_ready  (resp_ready),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_respack (bus_respack),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag)
  );

  typedef struct {
    logic [2:0] valid;
    int         exp_rr;
    int         exp_fixed;
    int         ack_dly;
    logic [7:0] bp;
    bit         stray;
    bit         drop;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] line_addr(input int idx);
    case (idx)
      0:       return 64'h0000_0000_1000_0040;
      1:       return 64'h0000_0000_2000_0080;
      default: return 64'h0000_0000_3000_00C0;
    endcase
  endfunction

  function automatic int pick(input vec_t v);
`ifdef SYSBUS_ARB_FIXED_PRIO_EN
    return v.exp_fixed;
`else
    return v.exp_rr;
`endif
  endfunction

  task automatic run_txn(input logic [2:0] v, input int owner, input int ack_dly,
                         input logic [7:0] bp, input bit stray, input bit drop,
                         input logic [2:0] nxt);
    logic [2:0]  oh;
    logic [63:0] data;
    oh = 3'b001 << owner;
    req_valid   = v;
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    resp_ready  = 3'b111;
    step();
    chk("reqcyc_latency", {63'd0, bus_reqcyc}, 64'd1);
    chk("bus_req_aligned", bus_req, line_addr(owner));
    chk("bus_reqtag", {51'd0, bus_reqtag}, 64'h1100);
    for (int d = 0; d < ack_dly; d++) begin
      if (drop) req_valid = 3'b000;
      bus_respcyc = stray;
      bus_resp    = 64'hDEAD_BEEF_0000_0000;
      #1;
      chk("req_ready_wait", {61'd0, req_ready}, 64'd0);
      chk("bus_req_hold", bus_req, line_addr(owner));
      if (stray) begin
        chk("stray_req_respack", {63'd0, bus_respack}, 64'd0);
        chk("stray_req_respvalid", {61'd0, resp_valid}, 64'd0);
      end
      step();
    end
    bus_respcyc = 1'b0;
    bus_reqack  = 1'b1;
    #1;
    chk("req_ready_pulse", {61'd0, req_ready}, {61'd0, oh});
    step();
    bus_reqack = 1'b0;
    req_valid  = 3'b000;
    #1;
    chk("reqcyc_drop", {63'd0, bus_reqcyc}, 64'd0);
    chk("req_ready_once", {61'd0, req_ready}, 64'd0);
    for (int k = 0; k < 8; k++) begin
      data = 64'h11 * (k + 1);
      bus_respcyc = 1'b1;
      bus_resp    = data;
      if (bp[k]) begin
        resp_ready = ~oh;
        #1;
        chk("bp_respack", {63'd0, bus_respack}, 64'd0);
        chk("bp_respvalid", {61'd0, resp_valid}, {61'd0, oh});
        chk("bp_last", {63'd0, resp_last}, 64'd0);
        step();
        resp_ready = 3'b111;
      end
      #1;
      chk("beat_valid", {61'd0, resp_valid}, {61'd0, oh});
      chk("beat_data", resp_data, data);
      chk("beat_last", {63'd0, resp_last}, {63'd0, (k == 7)});
      chk("beat_respack", {63'd0, bus_respack}, 64'd1);
      if (k == 7) req_valid = nxt;
      step();
    end
    bus_respcyc = 1'b0;
    #1;
    chk("idle_gap_reqcyc", {63'd0, bus_reqcyc}, 64'd0);
    chk("idle_respvalid", {61'd0, resp_valid}, 64'd0);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    req_valid   = 3'b000;
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          valid   rr fx dly  bp           stray drop
    vecs[0] = '{3'b001, 0, 0, 3, 8'b0000_0000, 1'b1, 1'b0};
    vecs[1] = '{3'b111, 1, 1, 1, 8'b0000_0000, 1'b0, 1'b0};
    vecs[2] = '{3'b111, 2, 1, 2, 8'b0011_1000, 1'b0, 1'b0};
    vecs[3] = '{3'b111, 0, 1, 0, 8'b0000_0000, 1'b0, 1'b0};
    vecs[4] = '{3'b101, 2, 2, 1, 8'b0000_0000, 1'b1, 1'b0};
    vecs[5] = '{3'b010, 1, 1, 3, 8'b0000_0000, 1'b0, 1'b1};
    vecs[6] = '{3'b001, 0, 0, 1, 8'b0000_0000, 1'b0, 1'b0};

    req_addr    = {64'h0000_0000_3000_00FF, 64'h0000_0000_2000_0087, 64'h0000_0000_1000_0044};
    resp_ready  = 3'b111;
    bus_resp    = '0;
    bus_resptag = 13'h1FFF;
    do_reset();

    // Reset state, then stray beats while idle
    chk("rst_reqcyc", {63'd0, bus_reqcyc}, 64'd0);
    chk("rst_bus_req", bus_req, 64'd0);
    chk("rst_req_ready", {61'd0, req_ready}, 64'd0);
    chk("rst_reqtag", {51'd0, bus_reqtag}, 64'h1100);
    bus_respcyc = 1'b1;
    bus_resp    = 64'h5555;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("stray_idle_respack", {63'd0, bus_respack}, 64'd0);
      chk("stray_idle_respvalid", {61'd0, resp_valid}, 64'd0);
      step();
    end
    bus_respcyc = 1'b0;

    for (int i = 0; i < 7; i++)
      run_txn(vecs[i].valid, pick(vecs[i]), vecs[i].ack_dly, vecs[i].bp,
              vecs[i].stray, vecs[i].drop, 3'b000);

    // Back-to-back: ptw rises during the final beat of fetch's line
    do_reset();
    run_txn(3'b001, 0, 1, 8'h00, 1'b0, 1'b0, 3'b010);
    run_txn(3'b010, 1, 1, 8'h00, 1'b0, 1'b0, 3'b000);

    // Reset in the middle of a response
    req_valid = 3'b100;
    step();
    bus_reqack = 1'b1;
    step();
    bus_reqack = 1'b0;
    req_valid  = 3'b000;
    for (int k = 0; k < 5; k++) begin
      bus_respcyc = 1'b1;
      bus_resp    = 64'h11 * (k + 1);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("midrst_reqcyc", {63'd0, bus_reqcyc}, 64'd0);
    chk("midrst_respack", {63'd0, bus_respack}, 64'd0);
    chk("midrst_respvalid", {61'd0, resp_valid}, 64'd0);
    bus_respcyc = 1'b0;
    req_valid   = 3'b111;
    step();
`ifdef SYSBUS_ARB_FIXED_PRIO_EN
    chk("midrst_grant", bus_req, line_addr(1));
`else
    chk("midrst_rr_zero", bus_req, line_addr(0));
`endif
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
